conv_operand_loader: RTL and testbench
======================================

Name: conv_operand_loader

Overview:
- Sequential front end for the combinational convolution unit.
- Accepts a dimension configuration, then a byte stream over a valid/ready handshake, and packs it into the unified operand buses: a 400-bit matrices bus holding the image in the low 200 bits, and a 72-bit kernel bus.
- Presents dimensions and buses to the convolution unit and holds them stable while load_done is high.

Parameters:
- DATA_W, 8, element width in bits; only the default is supported, bus widths are fixed.
- IMG_MAX, 5, image slot grid is 5x5, row stride 5.
- KER_MAX, 3, kernel slot grid is 3x3, row stride 3.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous abort; returns to IDLE and zeroes all outputs
- cfg_valid  in  1  configuration strobe, sampled only in IDLE or DONE
- cfg_in_m  in  3  image rows
- cfg_in_n  in  3  image columns
- cfg_k_m  in  2  kernel rows
- cfg_k_n  in  2  kernel columns
- elem_valid  in  1  stream element valid
- elem_data  in  8  stream element, unsigned
- elem_ready  out  1  high in LOAD_IMG and LOAD_KER only
- in_m, in_n  out  3 each  latched image dimensions
- k_m, k_n  out  2 each  latched kernel dimensions
- matrices_in  out  400  packed image; bits [399:200] always zero
- kernelMatrix  out  72  packed kernel
- load_done  out  1  level; high in DONE only
- busy  out  1  high in LOAD_IMG and LOAD_KER
- cfg_err  out  1  one-cycle pulse when a rejected configuration is seen
- elem_count  out  6  elements accepted since the last configuration accept (0..34)
- load_cycles  out  10  cycles from configuration accept to entering DONE; saturates at 1023

Behaviour:
- Reset and clear: all outputs 0, state IDLE. Priority: reset > clear > cfg_valid > element handshake.
- Configuration is valid when all dimensions are nonzero, cfg_in_m and cfg_in_n ≤ 5, cfg_k_m and cfg_k_n ≤ 3, cfg_in_m ≥ cfg_k_m and cfg_in_n ≥ cfg_k_n.
- IDLE or DONE with cfg_valid and a valid configuration:
  - latch the dimensions;
  - zero matrices_in, kernelMatrix, elem_count and load_cycles;
  - reset row and column counters;
  - next state LOAD_IMG.
- IDLE or DONE with cfg_valid and an invalid configuration:
  - cfg_err = 1 for the next cycle only;
  - state and all other outputs unchanged.
- cfg_valid in LOAD_IMG or LOAD_KER is ignored; it produces no cfg_err.
- A transfer occurs when elem_valid and elem_ready are both high on a rising edge. elem_valid while elem_ready is low is dropped.
- LOAD_IMG:
  - on each transfer, write elem_data to matrices_in[((r*5+c)*8) +: 8];
  - c increments, wrapping to 0 with r+1 when c = in_n-1;
  - on the transfer with r = in_m-1 and c = in_n-1, move to LOAD_KER and reset the counters;
  - image order is row-major, and slots outside in_m x in_n stay 0.
- LOAD_KER:
  - same scheme into kernelMatrix[((r*3+c)*8) +: 8], using k_m and k_n;
  - the last kernel transfer moves to DONE.
- No bubbles between phases: elem_ready stays high across the LOAD_IMG to LOAD_KER boundary, so back-to-back transfers are accepted.
- elem_count increments on every transfer and equals in_m*in_n + k_m*k_n in DONE.
- load_cycles:
  - increments every cycle while busy, saturating at 1023;
  - with back-to-back data its value in DONE equals the element count;
  - it freezes in DONE.
- DONE:
  - load_done = 1, elem_ready = 0, all buses and dimensions held;
  - remains in DONE until clear, reset, or a valid cfg_valid (which restarts the load).
- clear mid-load discards partial data; the next configuration starts from zero.

Decomposition:
- Shared package conv_pkg holds:
  - constants IMG_MAX=5, KER_MAX=3, DATA_W=8, MAT_BUS_W=400, KER_BUS_W=72, IMG_BUS_W=200;
  - the state enum {IDLE, LOAD_IMG, LOAD_KER, DONE};
  - a function dims_valid(in_m, in_n, k_m, k_n), reused by the convolution unit.
- One natural sub-module, grid_index_counter: row/column counter with programmable limits, a wrap flag and a last flag. It is instantiated once and reloaded between phases.

Test Plan:
- Config 3x3 image, 2x2 kernel; stream 1..9 then 1,0,0,1 back-to-back → load_done after 13 transfers; matrices_in[7:0]=1, [23:16]=3, [47:40]=4, [103:96]=9; slot (0,3) [31:24]=0; kernelMatrix[7:0]=1, [31:24]=0 (slot (1,0)), [39:32]=1 (slot (1,1)); elem_count=13, load_cycles=13.
- Config in_m=2, k_m=3 → cfg_err pulses exactly 1 cycle, state stays IDLE, elem_ready=0, outputs unchanged.
- 5x5/3x3 load with elem_valid toggling every other cycle → 34 transfers, all data correctly placed, load_cycles=67, matrices_in[399:200]=0.
- clear asserted after 7 image elements → next cycle all outputs 0 and IDLE; a new 1x1/1x1 load of 0xAA, 0x55 gives matrices_in[7:0]=0xAA, kernelMatrix[7:0]=0x55, all other bytes 0.
- In DONE, apply a valid new config 4x4/3x3 in the same cycle as clear → clear wins, state IDLE. Then apply the config alone → LOAD_IMG, buses zeroed, elem_count=0.
- cfg_valid mid-LOAD_IMG with different dimensions → ignored, no cfg_err, original dimensions retained; reset mid-load → all outputs 0 on the next edge.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath.
// Holds the bus geometry constants, the operand-loader state encoding and
// the dimension legality check. The convolution unit reuses dims_valid.
package conv_pkg;

  localparam int IMG_MAX   = 5;
  localparam int KER_MAX   = 3;
  localparam int DATA_W    = 8;
  localparam int MAT_BUS_W = 400;
  localparam int KER_BUS_W = 72;
  localparam int IMG_BUS_W = 200;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_IMG = 2'd1,
    LOAD_KER = 2'd2,
    DONE     = 2'd3
  } load_state_e;

  // All dimensions nonzero, within the slot grids, and kernel no larger
  // than the image in either direction.
  function automatic logic dims_valid(input logic [2:0] in_m,
                                      input logic [2:0] in_n,
                                      input logic [1:0] k_m,
                                      input logic [1:0] k_n);
    return (in_m != 3'd0) && (in_n != 3'd0) &&
           (k_m != 2'd0) && (k_n != 2'd0) &&
           (in_m <= 3'd5) && (in_n <= 3'd5) &&
           (in_m >= {1'b0, k_m}) && (in_n >= {1'b0, k_n});
  endfunction

endpackage

// File: rtl/conv_operand_loader_grid_index_counter.sv
// grid_index_counter: row/column index over a num_rows x num_cols grid.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   restart       - return both indices to 0 (takes priority over step)
//   step          - advance one slot in row-major order
//   num_rows/cols - current grid extent (1..7), may change between phases
//   row, col      - current slot
//   wrap          - col is on the final column (the next step wraps)
//   last          - row is on the final row; wrap && last marks the final slot
module grid_index_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic       step,
  input  logic [2:0] num_rows,
  input  logic [2:0] num_cols,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       wrap,
  output logic       last
);

  assign wrap = (col == num_cols - 3'd1);
  assign last = (row == num_rows - 3'd1);

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      row <= 3'd0;
      col <= 3'd0;
    end else if (step) begin
      if (wrap) begin
        col <= 3'd0;
        row <= row + 3'd1;
      end else begin
        col <= col + 3'd1;
      end
    end
  end

endmodule

// File: rtl/conv_operand_loader.sv
// conv_operand_loader: sequential front end for the convolution unit.
// Takes a dimension configuration, then a byte stream (image row-major,
// then kernel row-major) and packs it into the operand buses.
// Handshake: a byte moves on a rising edge where elem_valid and elem_ready
// are both high; elem_ready depends only on state, never on elem_valid,
// and a byte offered while elem_ready is low is simply not taken.
// Ports:
//   clk, reset, clear       - clock, sync reset, sync abort to IDLE
//   cfg_valid, cfg_*        - configuration strobe and dimensions
//   elem_valid/data/ready   - element stream
//   in_m, in_n, k_m, k_n    - latched dimensions
//   matrices_in             - image in bits [199:0], upper half zero
//   kernelMatrix            - packed 3x3 kernel slots
//   load_done, busy         - DONE / loading status levels
//   cfg_err                 - one-cycle pulse on a rejected configuration
//   elem_count, load_cycles - transfer and busy-cycle counters
//   dbg_state               - current FSM state
module conv_operand_loader
  import conv_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         cfg_valid,
  input  logic [2:0]   cfg_in_m,
  input  logic [2:0]   cfg_in_n,
  input  logic [1:0]   cfg_k_m,
  input  logic [1:0]   cfg_k_n,
  input  logic         elem_valid,
  input  logic [7:0]   elem_data,
  output logic         elem_ready,
  output logic [2:0]   in_m,
  output logic [2:0]   in_n,
  output logic [1:0]   k_m,
  output logic [1:0]   k_n,
  output logic [399:0] matrices_in,
  output logic [71:0]  kernelMatrix,
  output logic         load_done,
  output logic         busy,
  output logic         cfg_err,
  output logic [5:0]   elem_count,
  output logic [9:0]   load_cycles,
  output logic [1:0]   dbg_state
);

  load_state_e          state;
  logic [IMG_BUS_W-1:0] img_bus;
  logic [2:0]           row, col, num_rows, num_cols;
  logic                 wrap, last, grid_end;
  logic                 xfer, cfg_window, cfg_accept;
  logic [4:0]           img_slot;
  logic [3:0]           ker_slot;
  logic [7:0]           img_off;
  logic [6:0]           ker_off;

  assign busy        = (state == LOAD_IMG) || (state == LOAD_KER);
  assign elem_ready  = busy;
  assign load_done   = (state == DONE);
  assign dbg_state   = state;
  assign matrices_in = {{(MAT_BUS_W-IMG_BUS_W){1'b0}}, img_bus};

  assign xfer       = elem_valid && elem_ready;
  assign cfg_window = (state == IDLE) || (state == DONE);
  assign cfg_accept = cfg_window && cfg_valid &&
                      dims_valid(cfg_in_m, cfg_in_n, cfg_k_m, cfg_k_n);
  assign grid_end   = wrap && last;

  // One counter serves both phases; its limits follow the active phase.
  assign num_rows = (state == LOAD_KER) ? {1'b0, k_m} : in_m;
  assign num_cols = (state == LOAD_KER) ? {1'b0, k_n} : in_n;

  assign img_slot = {2'b00, row} * 5'd5 + {2'b00, col};
  assign ker_slot = {1'b0, row} * 4'd3 + {1'b0, col};
  assign img_off  = {img_slot, 3'b000};
  assign ker_off  = {ker_slot, 3'b000};

  grid_index_counter u_idx (
    .clk      (clk),
    .reset    (reset),
    .restart  (clear || cfg_accept || (xfer && grid_end)),
    .step     (xfer),
    .num_rows (num_rows),
    .num_cols (num_cols),
    .row      (row),
    .col      (col),
    .wrap     (wrap),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state        <= IDLE;
      in_m         <= 3'd0;
      in_n         <= 3'd0;
      k_m          <= 2'd0;
      k_n          <= 2'd0;
      img_bus      <= '0;
      kernelMatrix <= '0;
      cfg_err      <= 1'b0;
      elem_count   <= 6'd0;
      load_cycles  <= 10'd0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_window && cfg_valid) begin
        if (cfg_accept) begin
          in_m         <= cfg_in_m;
          in_n         <= cfg_in_n;
          k_m          <= cfg_k_m;
          k_n          <= cfg_k_n;
          img_bus      <= '0;
          kernelMatrix <= '0;
          elem_count   <= 6'd0;
          load_cycles  <= 10'd0;
          state        <= LOAD_IMG;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (busy) begin
        if (load_cycles != 10'd1023) load_cycles <= load_cycles + 10'd1;
        if (xfer) begin
          elem_count <= elem_count + 6'd1;
          if (state == LOAD_IMG) begin
            img_bus[img_off +: 8] <= elem_data;
            if (grid_end) state <= LOAD_KER;
          end else begin
            kernelMatrix[ker_off +: 8] <= elem_data;
            if (grid_end) state <= DONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_operand_loader.sv
module tb_conv_operand_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1, clear = 1'b0, cfg_valid = 1'b0;
  logic [2:0]   cfg_in_m = '0, cfg_in_n = '0;
  logic [1:0]   cfg_k_m = '0, cfg_k_n = '0;
  logic         elem_valid = 1'b0;
  logic [7:0]   elem_data = '0;
  logic         elem_ready;
  logic [2:0]   in_m, in_n;
  logic [1:0]   k_m, k_n;
  logic [399:0] matrices_in;
  logic [71:0]  kernelMatrix;
  logic         load_done, busy, cfg_err;
  logic [5:0]   elem_count;
  logic [9:0]   load_cycles;
  logic [1:0]   dbg_state;

  conv_operand_loader dut (
    .clk(clk), .reset(reset), .clear(clear), .cfg_valid(cfg_valid),
    .cfg_in_m(cfg_in_m), .cfg_in_n(cfg_in_n), .cfg_k_m(cfg_k_m), .cfg_k_n(cfg_k_n),
    .elem_valid(elem_valid), .elem_data(elem_data), .elem_ready(elem_ready),
    .in_m(in_m), .in_n(in_n), .k_m(k_m), .k_n(k_n),
    .matrices_in(matrices_in), .kernelMatrix(kernelMatrix),
    .load_done(load_done), .busy(busy), .cfg_err(cfg_err),
    .elem_count(elem_count), .load_cycles(load_cycles), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [399:0] act, input logic [399:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // The model keeps the accepted bytes in arrival order; phase, counts and
  // bus contents are all derived from that list and the latched dimensions.
  logic [7:0] exp_q[$];
  int  m_im = 0, m_in = 0, m_km = 0, m_kn = 0;
  int  m_cycles = 0;
  bit  m_active = 1'b0;
  bit  m_err = 1'b0;

  function automatic bit cfg_legal(int im, int inn, int km, int kn);
    return im >= 1 && im <= 5 && inn >= 1 && inn <= 5 &&
           km >= 1 && km <= 3 && kn >= 1 && kn <= 3 && im >= km && inn >= kn;
  endfunction

  // 0 idle, 1 image phase, 2 kernel phase, 3 done
  function automatic int m_mode();
    int img_n, tot;
    if (!m_active) return 0;
    img_n = m_im * m_in;
    tot   = img_n + m_km * m_kn;
    if (exp_q.size() < img_n) return 1;
    if (exp_q.size() < tot) return 2;
    return 3;
  endfunction

  always @(posedge clk) begin : model
    int md;
    bit err_n;
    md = m_mode();
    if (reset || clear) begin
      m_active = 1'b0; m_im = 0; m_in = 0; m_km = 0; m_kn = 0;
      m_cycles = 0; m_err = 1'b0;
      exp_q.delete();
    end else begin
      err_n = 1'b0;
      if ((md == 0 || md == 3) && cfg_valid) begin
        if (cfg_legal(int'(cfg_in_m), int'(cfg_in_n), int'(cfg_k_m), int'(cfg_k_n))) begin
          m_im = int'(cfg_in_m); m_in = int'(cfg_in_n);
          m_km = int'(cfg_k_m);  m_kn = int'(cfg_k_n);
          m_active = 1'b1; m_cycles = 0;
          exp_q.delete();
        end else begin
          err_n = 1'b1;
        end
      end else if (md == 1 || md == 2) begin
        if (m_cycles < 1023) m_cycles++;
        if (elem_valid) exp_q.push_back(elem_data);
      end
      m_err = err_n;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin : compare
    logic [399:0] em;
    logic [71:0]  ek;
    int img_n, s, j, md;
    if (chk_en) begin
      em = '0; ek = '0;
      img_n = m_im * m_in;
      foreach (exp_q[i]) begin
        if (i < img_n) begin
          s = (i / m_in) * 5 + (i % m_in);
          em[s*8 +: 8] = exp_q[i];
        end else begin
          j = i - img_n;
          s = (j / m_kn) * 3 + (j % m_kn);
          ek[s*8 +: 8] = exp_q[i];
        end
      end
      md = m_mode();
      chkw("state",       32'(dbg_state),   32'(md));
      chkw("elem_ready",  32'(elem_ready),  32'(md == 1 || md == 2));
      chkw("busy",        32'(busy),        32'(md == 1 || md == 2));
      chkw("load_done",   32'(load_done),   32'(md == 3));
      chkw("cfg_err",     32'(cfg_err),     32'(m_err));
      chkw("dims",        32'({in_m, in_n, k_m, k_n}),
           32'({3'(m_im), 3'(m_in), 2'(m_km), 2'(m_kn)}));
      chkw("elem_count",  32'(elem_count),  32'(exp_q.size()));
      chkw("load_cycles", 32'(load_cycles), 32'(m_cycles));
      chk("matrices_in",  matrices_in, em);
      chk("kernelMatrix", 400'(kernelMatrix), 400'(ek));
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] drv_q[$];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_cfg(input int im, input int inn, input int km, input int kn);
    cfg_in_m = 3'(im); cfg_in_n = 3'(inn); cfg_k_m = 2'(km); cfg_k_n = 2'(kn);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Sends drv_q; gap=1 idles one cycle after each byte.
  task automatic send_q(input bit gap);
    foreach (drv_q[i]) begin
      elem_valid = 1'b1;
      elem_data  = drv_q[i];
      tick();
      if (gap) begin
        elem_valid = 1'b0;
        elem_data  = 8'($urandom);
        tick();
      end
    end
    elem_valid = 1'b0;
  endtask

  task automatic run_random(input int pct, input int abort_at);
    int cyc;
    cyc = 0;
    while ((m_mode() == 1 || m_mode() == 2) && cyc < 5000) begin
      elem_valid = ($urandom_range(0, 99) < pct);
      elem_data  = 8'($urandom);
      clear      = (cyc == abort_at);
      tick();
      cyc++;
    end
    clear = 1'b0;
    elem_valid = 1'b0;
    chkw("load_budget", 32'(cyc < 5000), 32'd1);
  endtask

  task automatic random_cfg();
    int im, inn, km, kn;
    if ($urandom_range(0, 99) < 80) begin
      im = $urandom_range(1, 5); inn = $urandom_range(1, 5);
      km = $urandom_range(1, (im < 3) ? im : 3);
      kn = $urandom_range(1, (inn < 3) ? inn : 3);
    end else begin
      im = $urandom_range(0, 7); inn = $urandom_range(0, 7);
      km = $urandom_range(0, 3); kn = $urandom_range(0, 3);
    end
    apply_cfg(im, inn, km, kn);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    tick(); tick();
    chk_en = 1'b1;
    chkw("reset_done", 32'(load_done), 32'd0);
    chkw("reset_ready", 32'(elem_ready), 32'd0);
    reset = 1'b0;
    tick();

    // 3x3 image, 2x2 kernel, back-to-back
    apply_cfg(3, 3, 2, 2);
    drv_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd1, 8'd0, 8'd0, 8'd1};
    send_q(1'b0);
    chkw("t1_done",   32'(load_done), 32'd1);
    chkw("t1_m0",     32'(matrices_in[7:0]), 32'd1);
    chkw("t1_m2",     32'(matrices_in[23:16]), 32'd3);
    chkw("t1_m03",    32'(matrices_in[31:24]), 32'd0);
    chkw("t1_m5",     32'(matrices_in[47:40]), 32'd4);
    chkw("t1_m12",    32'(matrices_in[103:96]), 32'd9);
    chkw("t1_k0",     32'(kernelMatrix[7:0]), 32'd1);
    chkw("t1_k3",     32'(kernelMatrix[31:24]), 32'd0);
    chkw("t1_k4",     32'(kernelMatrix[39:32]), 32'd1);
    chkw("t1_count",  32'(elem_count), 32'd13);
    chkw("t1_cycles", 32'(load_cycles), 32'd13);
    tick();

    // rejected configuration from IDLE
    clear = 1'b1; tick(); clear = 1'b0;
    apply_cfg(2, 2, 3, 1);
    chkw("t2_err_hi", 32'(cfg_err), 32'd1);
    chkw("t2_idle",   32'(dbg_state), 32'd0);
    tick();
    chkw("t2_err_lo", 32'(cfg_err), 32'd0);
    chkw("t2_ready",  32'(elem_ready), 32'd0);

    // 5x5/3x3 with elem_valid on every other cycle
    apply_cfg(5, 5, 3, 3);
    drv_q.delete();
    for (int i = 0; i < 34; i++) drv_q.push_back(8'($urandom_range(1, 255)));
    send_q(1'b1);
    chkw("t3_done",   32'(load_done), 32'd1);
    chkw("t3_count",  32'(elem_count), 32'd34);
    chkw("t3_cycles", 32'(load_cycles), 32'd67);
    chk("t3_upper",   400'(matrices_in[399:200]), 400'd0);
    chkw("t3_first",  32'(matrices_in[7:0]), 32'(drv_q[0]));
    chkw("t3_klast",  32'(kernelMatrix[71:64]), 32'(drv_q[33]));

    // clear after 7 image elements, then 1x1/1x1
    apply_cfg(3, 3, 2, 2);
    drv_q = '{8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17};
    send_q(1'b0);
    clear = 1'b1; tick(); clear = 1'b0;
    chkw("t4_idle",  32'(dbg_state), 32'd0);
    chkw("t4_count", 32'(elem_count), 32'd0);
    chk("t4_mat",    matrices_in, 400'd0);
    apply_cfg(1, 1, 1, 1);
    drv_q = '{8'hAA, 8'h55};
    send_q(1'b0);
    chk("t4_mat_aa", matrices_in, 400'hAA);
    chk("t4_ker_55", 400'(kernelMatrix), 400'h55);

    // clear beats a simultaneous valid configuration in DONE
    clear = 1'b1;
    apply_cfg(4, 4, 3, 3);
    clear = 1'b0;
    chkw("t5_idle", 32'(dbg_state), 32'd0);
    chkw("t5_in_m", 32'(in_m), 32'd0);
    apply_cfg(4, 4, 3, 3);
    chkw("t5_load",  32'(dbg_state), 32'd1);
    chkw("t5_count", 32'(elem_count), 32'd0);
    chk("t5_mat",    matrices_in, 400'd0);
    run_random(100, -1);

    // cfg_valid mid-load is ignored; reset mid-load clears everything
    apply_cfg(4, 4, 2, 2);
    drv_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    send_q(1'b0);
    elem_valid = 1'b1; elem_data = 8'd6;
    apply_cfg(2, 2, 1, 1);
    elem_valid = 1'b0;
    chkw("t6_in_m", 32'(in_m), 32'd4);
    chkw("t6_err",  32'(cfg_err), 32'd0);
    chkw("t6_count", 32'(elem_count), 32'd6);
    reset = 1'b1; tick(); reset = 1'b0;
    chkw("t6_rst_count", 32'(elem_count), 32'd0);
    chk("t6_rst_mat",    matrices_in, 400'd0);
    chkw("t6_rst_idle",  32'(dbg_state), 32'd0);

    // load_cycles saturation with a sparse stream
    apply_cfg(5, 5, 3, 3);
    run_random(3, -1);
    tick();

    // randomized loads, invalid configs, aborts, dropped data in DONE/IDLE
    for (int it = 0; it < 25; it++) begin
      random_cfg();
      run_random($urandom_range(20, 100),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1);
      for (int d = 0; d < 3; d++) begin
        elem_valid = 1'b1; elem_data = 8'($urandom);
        tick();
      end
      elem_valid = 1'b0;
      tick();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
